// File: rtl/gcd_arbiter.sv
// Round-robin arbiter that shares one gcd_core between N_REQ requesters.
// Optional watchdog: define GCD_ARB_TIMEOUT_EN to abort operations stuck waiting on core_done.
module gcd_arbiter #(
  parameter int unsigned N_REQ          = 4,
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_x,
  input  logic [N_REQ*WIDTH-1:0] req_y,
  output logic [N_REQ-1:0]       resp_valid,
  output logic [WIDTH-1:0]       resp_result,
  output logic                   resp_error,
  output logic                   busy,
  output logic                   core_load,
  output logic [WIDTH-1:0]       core_data,
  input  logic                   core_done,
  input  logic [WIDTH-1:0]       core_result
);

  localparam int unsigned IW = $clog2(N_REQ);
  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, SEND_X, SEND_Y, WAIT_LOW, WAIT_DONE, RESPOND
  } state_t;

  state_t           state, state_next;
  logic [IW-1:0]    rr_ptr, idx_q, grant_idx;
  logic             grant_any;
  logic [WIDTH-1:0] x_q, y_q;
  logic             timeout_hit;

  // First set request at or above rr_ptr, wrapping back to 0.
  always_comb begin
    int unsigned j;
    j         = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      j = 32'(rr_ptr) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!grant_any && req[j]) begin
        grant_any = 1'b1;
        grant_idx = IW'(j);
      end
    end
  end

`ifdef GCD_ARB_TIMEOUT_EN
  localparam logic [CW-1:0] TO_MAX = CW'(TIMEOUT_CYCLES);
  logic [CW-1:0] to_cnt;
  logic          err_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      to_cnt <= '0;
      err_q  <= 1'b0;
    end else begin
      if (state == SEND_Y)
        to_cnt <= '0;
      else if (state == WAIT_LOW || state == WAIT_DONE)
        to_cnt <= to_cnt + 1'b1;
      if (timeout_hit)
        err_q <= 1'b1;
      else if (state == IDLE)
        err_q <= 1'b0;
    end
  end

  assign timeout_hit = (state == WAIT_LOW || state == WAIT_DONE) && (to_cnt == TO_MAX);
  assign resp_error  = err_q && (state == RESPOND);
`else
  logic [CW-1:0] timeout_unused;
  assign timeout_unused = '0;
  assign timeout_hit    = 1'b0;
  assign resp_error     = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (grant_any) state_next = LOAD;
      LOAD:      state_next = SEND_X;
      SEND_X:    state_next = SEND_Y;
      SEND_Y:    state_next = WAIT_LOW;
      WAIT_LOW:  if (!core_done) state_next = WAIT_DONE;
      WAIT_DONE: if (core_done) state_next = RESPOND;
      RESPOND:   state_next = IDLE;
      default:   state_next = IDLE;
    endcase
    if (timeout_hit) state_next = RESPOND;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rr_ptr      <= '0;
      idx_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      resp_result <= '0;
    end else begin
      if (state == IDLE && grant_any) begin
        idx_q <= grant_idx;
        x_q   <= req_x[grant_idx*WIDTH +: WIDTH];
        y_q   <= req_y[grant_idx*WIDTH +: WIDTH];
      end
      if (timeout_hit)
        resp_result <= '0;
      else if (state == WAIT_DONE && core_done)
        resp_result <= core_result;
      if (state == RESPOND)
        rr_ptr <= (idx_q == IW'(N_REQ - 1)) ? '0 : idx_q + 1'b1;
    end
  end

  always_comb begin
    busy       = (state != IDLE);
    core_load  = (state == LOAD);
    core_data  = '0;
    resp_valid = '0;
    case (state)
      SEND_X:  core_data = x_q;
      SEND_Y:  core_data = y_q;
      RESPOND: resp_valid[idx_q] = 1'b1;
      default: core_data = '0;
    endcase
  end

endmodule

// File: tb/tb_gcd_arbiter.sv
// Directed bench for gcd_arbiter with a behavioural gcd_core model.
module tb_gcd_arbiter;

  logic        clock, reset;
  logic [3:0]  req;
  logic [31:0] req_x, req_y;
  logic [3:0]  resp_valid;
  logic [7:0]  resp_result;
  logic        resp_error, busy, core_load;
  logic [7:0]  core_data;
  logic        core_done;
  logic [7:0]  core_result;

  int checks = 0;
  int errors = 0;

  gcd_arbiter #(.N_REQ(4), .WIDTH(8), .TIMEOUT_CYCLES(20)) dut (
    .clock(clock), .reset(reset), .req(req), .req_x(req_x), .req_y(req_y),
    .resp_valid(resp_valid), .resp_result(resp_result), .resp_error(resp_error),
    .busy(busy), .core_load(core_load), .core_data(core_data),
    .core_done(core_done), .core_result(core_result)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Behavioural core: captures x then y after load, holds stale done for
  // stale_hold cycles, then drops done and raises it 10 cycles later.
  int unsigned m_phase, m_cnt, stale_hold;
  bit          stuck_low;
  logic [7:0]  m_x, m_y;

  function automatic logic [7:0] gcd(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      m_phase <= 0; m_cnt <= 0; core_done <= 1'b1; core_result <= '0;
    end else if (core_load) begin
      m_phase <= 1;
    end else begin
      case (m_phase)
        1: begin m_x <= core_data; m_phase <= 2; end
        2: begin m_y <= core_data; m_phase <= 3; m_cnt <= 0; end
        3: begin
          m_cnt <= m_cnt + 1;
          if (m_cnt >= stale_hold) core_done <= 1'b0;
          if (!stuck_low && m_cnt == stale_hold + 10) begin
            core_done <= 1'b1; core_result <= gcd(m_x, m_y); m_phase <= 0;
          end
        end
        default: ;
      endcase
    end
  end

  task automatic set_op(input int i, input logic [7:0] x, input logic [7:0] y);
    req_x[i*8 +: 8] = x;
    req_y[i*8 +: 8] = y;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; req = '0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic wait_resp(output int cyc, output bit ok);
    cyc = 0; ok = 1'b0;
    while (cyc < 300 && !ok) begin
      @(negedge clock);
      cyc++;
      if (resp_valid !== 4'b0000) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid: got %b expected 0000", resp_valid); end
    checks++; if (core_load !== 1'b0) begin errors++; $display("FAIL reset_load: got %b expected 0", core_load); end
    checks++; if (core_data !== 8'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", core_data); end
    checks++; if (resp_result !== 8'd0) begin errors++; $display("FAIL reset_result: got %0d expected 0", resp_result); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b expected 0", resp_error); end
  endtask

  task automatic test_single();
    int cyc; bit ok;
    do_reset();
    set_op(0, 8'd48, 8'd18);
    req = 4'b0001;
    @(negedge clock);
    checks++; if (core_load !== 1'b1) begin errors++; $display("FAIL single_load: got %b expected 1", core_load); end
    checks++; if (core_data !== 8'd0) begin errors++; $display("FAIL single_data_load: got %0d expected 0", core_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b expected 1", busy); end
    @(negedge clock);
    checks++; if (core_load !== 1'b0) begin errors++; $display("FAIL single_load_width: got %b expected 0", core_load); end
    checks++; if (core_data !== 8'd48) begin errors++; $display("FAIL single_data_x: got %0d expected 48", core_data); end
    @(negedge clock);
    checks++; if (core_data !== 8'd18) begin errors++; $display("FAIL single_data_y: got %0d expected 18", core_data); end
    wait_resp(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL single_timeout: got no resp_valid expected a pulse"); end
    checks++; if (cyc != 13) begin errors++; $display("FAIL single_latency: got %0d expected 13", cyc); end
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL single_valid: got %b expected 0001", resp_valid); end
    checks++; if (resp_result !== 8'd6) begin errors++; $display("FAIL single_result: got %0d expected 6", resp_result); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL single_error: got %b expected 0", resp_error); end
    req = '0;
    @(negedge clock);
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL single_pulse_width: got %b expected 0000", resp_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b expected 0", busy); end
    checks++; if (resp_result !== 8'd6) begin errors++; $display("FAIL single_hold: got %0d expected 6", resp_result); end
  endtask

  task automatic test_simultaneous();
    int cyc; bit ok;
    do_reset();
    set_op(1, 8'd12, 8'd8);
    set_op(2, 8'd35, 8'd21);
    req = 4'b0110;
    wait_resp(cyc, ok);
    checks++; if (!ok) begin errors++; $display("FAIL sim_first_timeout: got no resp_valid expected a pulse"); end
    checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL sim_first_valid: got %b expected 0010", resp_valid); end
    checks++; if (resp_result !== 8'd4) begin errors++; $display("FAIL sim_first_result: got %0d expected 4", resp_result); end
    req[1] = 1'b0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sim_gap_idle: got %b expected 0", busy); end
    @(negedge clock);
    checks++; if (core_load !== 1'b1) begin errors++; $display("FAIL sim_back_to_back_load: got %b expected 1", core_load); end
    wait_resp(cyc, ok);
    checks++; if (cyc != 15) begin errors++; $display("FAIL sim_second_latency: got %0d expected 15", cyc); end
    checks++; if (resp_valid !== 4'b0100) begin errors++; $display("FAIL sim_second_valid: got %b expected 0100", resp_valid); end
    checks++; if (resp_result !== 8'd7) begin errors++; $display("FAIL sim_second_result: got %0d expected 7", resp_result); end
    req = '0;
  endtask

  task automatic test_fairness();
    int cyc; bit ok;
    logic [3:0] seen;
    logic [3:0] exp_v [4];
    logic [7:0] exp_r [4];
    exp_v = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_r = '{8'd6, 8'd4, 8'd7, 8'd3};
    do_reset();
    set_op(0, 8'd48, 8'd18); set_op(1, 8'd12, 8'd8);
    set_op(2, 8'd35, 8'd21); set_op(3, 8'd9, 8'd6);
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      wait_resp(cyc, ok);
      checks++; if (resp_valid !== exp_v[k%4]) begin errors++; $display("FAIL fair_grant_%0d: got %b expected %b", k, resp_valid, exp_v[k%4]); end
      checks++; if (resp_result !== exp_r[k%4]) begin errors++; $display("FAIL fair_result_%0d: got %0d expected %0d", k, resp_result, exp_r[k%4]); end
      seen = resp_valid;
      req = req & ~seen;
      @(negedge clock);
      req = req | seen;
    end
    req = '0;
  endtask

  task automatic test_stale_done();
    int cyc; bit ok;
    do_reset();
    stale_hold = 6;
    set_op(0, 8'd20, 8'd8);
    req = 4'b0001;
    @(negedge clock);
    checks++; if (core_load !== 1'b1) begin errors++; $display("FAIL stale_load: got %b expected 1", core_load); end
    wait_resp(cyc, ok);
    checks++; if (cyc != 21) begin errors++; $display("FAIL stale_latency: got %0d expected 21", cyc); end
    checks++; if (resp_valid !== 4'b0001) begin errors++; $display("FAIL stale_valid: got %b expected 0001", resp_valid); end
    checks++; if (resp_result !== 8'd4) begin errors++; $display("FAIL stale_result: got %0d expected 4", resp_result); end
    req = '0;
    stale_hold = 0;
  endtask

  task automatic test_reset_mid();
    int cyc; bit ok;
    int stray;
    do_reset();
    set_op(2, 8'd48, 8'd18);
    req = 4'b0100;
    @(negedge clock);
    repeat (8) @(negedge clock);
    reset = 1'b1; req = '0;
    @(negedge clock);
    reset = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", busy); end
    checks++; if (core_load !== 1'b0) begin errors++; $display("FAIL rst_mid_load: got %b expected 0", core_load); end
    checks++; if (resp_valid !== 4'b0000) begin errors++; $display("FAIL rst_mid_valid: got %b expected 0000", resp_valid); end
    stray = 0;
    repeat (20) begin
      @(negedge clock);
      if (resp_valid !== 4'b0000) stray++;
    end
    checks++; if (stray != 0) begin errors++; $display("FAIL rst_mid_stray: got %0d pulses expected 0", stray); end
    set_op(3, 8'd9, 8'd6);
    req = 4'b1000;
    wait_resp(cyc, ok);
    checks++; if (cyc != 16) begin errors++; $display("FAIL rst_mid_latency: got %0d expected 16", cyc); end
    checks++; if (resp_valid !== 4'b1000) begin errors++; $display("FAIL rst_mid_valid_after: got %b expected 1000", resp_valid); end
    checks++; if (resp_result !== 8'd3) begin errors++; $display("FAIL rst_mid_result: got %0d expected 3", resp_result); end
    req = '0;
  endtask

`ifdef GCD_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc; bit ok;
    do_reset();
    stuck_low = 1'b1;
    set_op(1, 8'd5, 8'd3);
    req = 4'b0010;
    @(negedge clock);
    checks++; if (core_load !== 1'b1) begin errors++; $display("FAIL to_load: got %b expected 1", core_load); end
    wait_resp(cyc, ok);
    checks++; if (cyc != 24) begin errors++; $display("FAIL to_latency: got %0d expected 24", cyc); end
    checks++; if (resp_valid !== 4'b0010) begin errors++; $display("FAIL to_valid: got %b expected 0010", resp_valid); end
    checks++; if (resp_error !== 1'b1) begin errors++; $display("FAIL to_error: got %b expected 1", resp_error); end
    checks++; if (resp_result !== 8'd0) begin errors++; $display("FAIL to_result: got %0d expected 0", resp_result); end
    req = '0;
    @(negedge clock);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL to_busy_drop: got %b expected 0", busy); end
    checks++; if (resp_error !== 1'b0) begin errors++; $display("FAIL to_error_drop: got %b expected 0", resp_error); end
    stuck_low = 1'b0;
  endtask
`endif

  initial begin
    reset = 1'b1; req = '0; req_x = '0; req_y = '0;
    stale_hold = 0; stuck_low = 1'b0;
    test_reset();
    test_single();
    test_simultaneous();
    test_fairness();
    test_stale_done();
    test_reset_mid();
`ifdef GCD_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
